// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: turns the latched IR opcode into the
// per-cycle datapath and RAM strobes for ld/ldi/st/ALU/immediate-ALU/halt.
module control_sequencer #(
  parameter logic [4:0] BUS_REG = 5'b00000,
  parameter logic [4:0] BUS_ZLO = 5'b10011,
  parameter logic [4:0] BUS_PC  = 5'b10100,
  parameter logic [4:0] BUS_MDR = 5'b10101,
  parameter logic [3:0] ALU_ADD = 4'b0011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        incPC,
  output logic        e_MAR,
  output logic        e_MDR,
  output logic        MDR_read,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        ram_read,
  output logic        ram_write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        e_Rin,
  output logic        e_Rout,
  output logic        BAout,
  output logic        imm_sel,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect,
  output logic        run,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    T0     = 4'd0,
    T1     = 4'd1,
    T1W    = 4'd2,
    T2     = 4'd3,
    T3     = 4'd4,
    T4     = 4'd5,
    T5     = 4'd6,
    T6     = 4'd7,
    T6W    = 4'd8,
    T7     = 4'd9,
    HALTED = 4'd10
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_q, state_d;
  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_addr, is_rr, is_ri, is_halt;
  logic [3:0] alu_code;
  logic       unused_ir_bits;

  assign opcode = IR[31:27];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_ir_bits = ^IR[26:0];

  always_comb begin
    is_ld   = (opcode == OP_LD);
    is_ldi  = (opcode == OP_LDI);
    is_st   = (opcode == OP_ST);
    is_addr = is_ld | is_ldi | is_st;
    is_rr   = (opcode == OP_ADD) | (opcode == OP_SUB) | (opcode == OP_AND) | (opcode == OP_OR);
    is_ri   = (opcode == OP_ADDI) | (opcode == OP_ANDI) | (opcode == OP_ORI);
    is_halt = (opcode == OP_HALT);
    alu_code = 4'b0000;
    case (opcode)
      OP_ADD, OP_ADDI: alu_code = ALU_ADD;
      OP_SUB:          alu_code = 4'b0100;
      OP_AND, OP_ANDI: alu_code = 4'b0101;
      OP_OR,  OP_ORI:  alu_code = 4'b0110;
      default:         alu_code = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = T0;
    case (state_q)
      T0:     state_d = T1;
      T1:     state_d = T1W;
      T1W:    state_d = T2;
      T2:     state_d = T3;
      T3: begin
        if (is_halt)                       state_d = HALTED;
        else if (is_addr | is_rr | is_ri)  state_d = T4;
        else                               state_d = T0;
      end
      T4:     state_d = T5;
      T5:     state_d = (is_ld | is_st) ? T6 : T0;
      T6:     state_d = is_ld ? T6W : T7;
      T6W:    state_d = T7;
      T7:     state_d = T0;
      HALTED: state_d = HALTED;
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= T0;
    else       state_q <= state_d;
  end

  // Strobes are held quiet for the whole reset interval, so T0 only drives
  // the bus once clear has dropped.
  always_comb begin
    incPC = 1'b0;  e_MAR = 1'b0;  e_MDR = 1'b0;  MDR_read = 1'b0;
    e_IR = 1'b0;   e_Y = 1'b0;    e_Z = 1'b0;    ram_read = 1'b0;
    ram_write = 1'b0; Gra = 1'b0; Grb = 1'b0;    Grc = 1'b0;
    e_Rin = 1'b0;  e_Rout = 1'b0; BAout = 1'b0;  imm_sel = 1'b0;
    ALU_op = 4'b0000;
    BusDataSelect = 5'b00000;
    if (!clear) begin
      case (state_q)
        T0: begin BusDataSelect = BUS_PC; e_MAR = 1'b1; incPC = 1'b1; end
        T1: ram_read = 1'b1;
        T1W: begin MDR_read = 1'b1; e_MDR = 1'b1; end
        T2: begin BusDataSelect = BUS_MDR; e_IR = 1'b1; end
        T3: begin
          if (is_addr) begin
            Grb = 1'b1; BAout = 1'b1; e_Y = 1'b1; BusDataSelect = BUS_REG;
          end else if (is_rr | is_ri) begin
            Grb = 1'b1; e_Rout = 1'b1; e_Y = 1'b1; BusDataSelect = BUS_REG;
          end
        end
        T4: begin
          if (is_addr) begin
            imm_sel = 1'b1; ALU_op = ALU_ADD; e_Z = 1'b1;
          end else if (is_rr) begin
            Grc = 1'b1; e_Rout = 1'b1; BusDataSelect = BUS_REG; ALU_op = alu_code; e_Z = 1'b1;
          end else if (is_ri) begin
            imm_sel = 1'b1; ALU_op = alu_code; e_Z = 1'b1;
          end
        end
        T5: begin
          if (is_ld | is_st) begin
            BusDataSelect = BUS_ZLO; e_MAR = 1'b1;
          end else if (is_ldi | is_rr | is_ri) begin
            BusDataSelect = BUS_ZLO; Gra = 1'b1; e_Rin = 1'b1;
          end
        end
        T6: begin
          if (is_ld) begin
            ram_read = 1'b1;
          end else if (is_st) begin
            Gra = 1'b1; e_Rout = 1'b1; BusDataSelect = BUS_REG; e_MDR = 1'b1;
          end
        end
        T6W: begin MDR_read = 1'b1; e_MDR = 1'b1; end
        T7: begin
          if (is_ld) begin
            BusDataSelect = BUS_MDR; Gra = 1'b1; e_Rin = 1'b1;
          end else if (is_st) begin
            ram_write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign run       = (state_q != HALTED);
  assign state_out = state_q;

endmodule
